inst_fetch_responder: RTL and testbench
=======================================

INST_FETCH_RESPONDER -- requirements
Module: inst_fetch_responder

Interface
REQ-001 Parameter LATENCY, default 2, memory access cycles per request; legal 1..4.
REQ-002 Parameter DEPTH_WORDS, default 1024, instruction words stored; power of two.
REQ-003 Parameter ADDR_BASE, default 32'h8000_0000, byte address of word 0.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 request_i  in  1  fetch request from the fetch unit.
REQ-007 instAddr_i  in  32  byte address of requested instruction.
REQ-008 flush_i  in  1  jump/redirect; discards all pending and in-flight requests.
REQ-009 memWe_i  in  1  backdoor program-load write enable.
REQ-010 memWAddr_i  in  32  backdoor word index, low log2(DEPTH_WORDS) bits used.
REQ-011 memWData_i  in  32  backdoor write data.
REQ-012 busy_o  out  1  request queue full; request_i ignored while high.
REQ-013 dataOk_o  out  1  one-cycle pulse: inst_o/instAddr_o/err_o valid.
REQ-014 inst_o  out  32  returned instruction word.
REQ-015 instAddr_o  out  32  address of returned instruction (echo).
REQ-016 err_o  out  1  returned access was misaligned or out of range.

Function
REQ-017 Request accepted in cycle N iff request_i=1, busy_o=0, flush_i=0; address pushed into 2-entry FIFO at end of N.
REQ-018 busy_o = FIFO holds 2 entries (combinational from state).
REQ-019 FSM states IDLE, WAIT, RESP.
REQ-020 IDLE: FIFO non-empty -> pop head, load counter LATENCY-1, go WAIT; else stay IDLE.
REQ-021 WAIT: counter decrements each cycle; at counter 0 read memory into inst_o register, go RESP.
REQ-022 RESP: dataOk_o=1 for exactly this cycle; then if FIFO non-empty pop and go WAIT directly, else IDLE.
REQ-023 Latency: request accepted in cycle N with empty FIFO and FSM IDLE -> dataOk_o high in cycle N+LATENCY+2.
REQ-024 Back-to-back throughput: one response every LATENCY+1 cycles while FIFO non-empty.
REQ-025 Responses returned strictly in acceptance order.
REQ-026 Push and pop in same cycle on full FIFO: push refused (busy_o=1); on 1-entry FIFO: both occur, count unchanged.
REQ-027 Word index = (instAddr - ADDR_BASE) >> 2, computed modulo 2^32.
REQ-028 Error if instAddr[1:0]!=0 or (instAddr - ADDR_BASE) >= DEPTH_WORDS*4: response still issued, inst_o=32'h0000_0013 (NOP), err_o=1 for that RESP cycle.
REQ-029 err_o=0 whenever dataOk_o=0.
REQ-030 inst_o and instAddr_o hold last returned values between responses.
REQ-031 flush_i=1 in any cycle: FIFO emptied, counter cleared, FSM to IDLE next cycle, request_i in that cycle discarded.
REQ-032 flush_i=1 during RESP: dataOk_o forced 0 that cycle (combinational gate), response lost.
REQ-033 Backdoor write takes effect at end of cycle; read in same cycle to same index returns old data (read-before-write).
REQ-034 Backdoor writes permitted at any time, independent of FSM state and flush_i.

Reset
REQ-035 reset_n=0 at a rising edge: FSM IDLE, FIFO empty, counter 0, dataOk_o=0, busy_o=0, err_o=0, inst_o=0, instAddr_o=0.
REQ-036 Reset mid-operation drops all pending and in-flight requests; no dataOk_o pulse until a new request is accepted after reset release.
REQ-037 Memory array contents not cleared by reset.
REQ-038 request_i and memWe_i ignored while reset_n=0.

Verification
REQ-039 Backdoor-load word 0 = 32'h0010_0093; LATENCY=2; request 32'h8000_0000 in cycle 10 -> dataOk_o=1 in cycle 14 only, inst_o=32'h0010_0093, instAddr_o=32'h8000_0000, err_o=0.
REQ-040 Hold request_i=1 with addresses 0x8000_0000,+4,+8 -> busy_o rises after 2 accepts, responses every 3 cycles in order, third accepted once a slot frees.
REQ-041 Request 32'h8000_0002 and 32'h7FFF_FFFC -> each returns inst_o=32'h0000_0013, err_o=1.
REQ-042 Two requests queued, flush_i pulsed while first in WAIT -> no dataOk_o for either; fresh request after flush returns normally at N+LATENCY+2.
REQ-043 reset_n=0 for one cycle while FSM in WAIT -> all outputs zero next cycle, no stale dataOk_o, memory contents retained.
REQ-044 Backdoor write index 5 in same cycle as its read -> old word returned; next request to index 5 returns new word.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// rtl/inst_fetch_responder.sv - instruction fetch responder with 2-entry request FIFO and backdoor-loaded memory
//
// Accepts byte-address fetch requests into a 2-entry FIFO, serves them in order
// with a fixed LATENCY-cycle memory access, and returns one response per request.
// Misaligned or out-of-range addresses return a NOP with err_o set.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   request_i, instAddr_i   fetch request and its byte address
//   flush_i                 discard all queued and in-flight requests
//   memWe_i, memWAddr_i,
//   memWData_i              backdoor program-load write (word index, data)
//   busy_o                  request FIFO full, request_i ignored
//   dataOk_o                one-cycle response strobe
//   inst_o, instAddr_o      returned instruction and its address
//   err_o                   returned access was misaligned or out of range
module inst_fetch_responder #(
    parameter int          LATENCY     = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        request_i,
    input  logic [31:0] instAddr_i,
    input  logic        flush_i,
    input  logic        memWe_i,
    input  logic [31:0] memWAddr_i,
    input  logic [31:0] memWData_i,
    output logic        busy_o,
    output logic        dataOk_o,
    output logic [31:0] inst_o,
    output logic [31:0] instAddr_o,
    output logic        err_o
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  CNT_LOAD = 2'(LATENCY - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [1:0]  r_cnt;
    logic [31:0] r_cur_addr;
    logic [31:0] r_inst;
    logic [31:0] r_inst_addr;
    logic        r_err;

    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_index;
    logic             w_bad;

    assign busy_o = (r_count == 2'd2);
    assign w_push = request_i & ~busy_o & ~flush_i;
    // The FSM only consumes the FIFO head from IDLE or from RESP (chained fetch).
    assign w_pop  = ~flush_i & (r_count != 2'd0) & ((r_state == S_IDLE) | (r_state == S_RESP));

    // Offset wraps modulo 2^32, so addresses below ADDR_BASE land far out of range.
    assign w_offset = r_cur_addr - ADDR_BASE;
    assign w_index  = w_offset[IDX_W+1:2];
    assign w_bad    = (r_cur_addr[1:0] != 2'b00) | ({1'b0, w_offset} >= SPAN);

    // Flush in the response cycle swallows the response.
    assign dataOk_o   = (r_state == S_RESP) & ~flush_i;
    assign err_o      = r_err & dataOk_o;
    assign inst_o     = r_inst;
    assign instAddr_o = r_inst_addr;

    // Program-load port; contents survive reset. Nonblocking write gives read-before-write.
    always_ff @(posedge clk) begin
        if (reset_n && memWe_i) begin
            r_mem[memWAddr_i[IDX_W-1:0]] <= memWData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_cnt       <= 2'd0;
            r_cur_addr  <= 32'd0;
            r_inst      <= 32'd0;
            r_inst_addr <= 32'd0;
            r_err       <= 1'b0;
        end else if (flush_i) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= instAddr_i;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_cur_addr <= r_fifo[r_rd_ptr];
                r_rd_ptr   <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_inst      <= w_bad ? NOP : r_mem[w_index];
                        r_inst_addr <= r_cur_addr;
                        r_err       <= w_bad;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (w_pop) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb/tb_inst_fetch_responder.sv - self-checking bench for inst_fetch_responder
module tb_inst_fetch_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        request_i;
    logic [31:0] instAddr_i;
    logic        flush_i;
    logic        memWe_i;
    logic [31:0] memWAddr_i;
    logic [31:0] memWData_i;
    logic        busy_o;
    logic        dataOk_o;
    logic [31:0] inst_o;
    logic [31:0] instAddr_o;
    logic        err_o;

    always #5 clk = ~clk;

    inst_fetch_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024), .ADDR_BASE(32'h8000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .request_i(request_i), .instAddr_i(instAddr_i),
        .flush_i(flush_i), .memWe_i(memWe_i), .memWAddr_i(memWAddr_i), .memWData_i(memWData_i),
        .busy_o(busy_o), .dataOk_o(dataOk_o), .inst_o(inst_o), .instAddr_o(instAddr_o), .err_o(err_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [31:0] idx, input logic [31:0] data);
        memWe_i = 1'b1; memWAddr_i = idx; memWData_i = data;
        tick();
        memWe_i = 1'b0;
    endtask

    task automatic watch_quiet(input string nm, input int cycles);
        logic stray;
        stray = 1'b0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (dataOk_o) stray = 1'b1;
            tick();
        end
        chk(nm, 32'(stray), 32'd0);
    endtask

    task automatic do_req(input string nm, input logic [31:0] a, input logic [31:0] ei, input logic ee);
        int          lat;
        logic [31:0] gi, ga;
        logic        ge, stray;
        lat = -1; gi = 32'd0; ga = 32'd0; ge = 1'b0; stray = 1'b0;
        request_i = 1'b1; instAddr_i = a;
        @(negedge clk);
        chk({nm, " busy"}, 32'(busy_o), 32'd0);
        tick();
        request_i = 1'b0;
        for (int j = 1; j <= 20 && lat < 0; j++) begin
            @(negedge clk);
            if (dataOk_o) begin
                lat = j; gi = inst_o; ga = instAddr_o; ge = err_o;
            end else if (err_o) begin
                stray = 1'b1;
            end
            tick();
        end
        @(negedge clk);
        chk({nm, " pulse_width"}, 32'(dataOk_o), 32'd0);
        chk({nm, " latency"}, 32'(lat), 32'(LAT + 2));
        chk({nm, " inst"}, gi, ei);
        chk({nm, " addr"}, ga, a);
        chk({nm, " err"}, 32'(ge), 32'(ee));
        chk({nm, " err_idle"}, 32'(stray), 32'd0);
        tick();
    endtask

    initial begin
        logic [31:0] ba [4];
        logic [31:0] bi [4];
        int          rt [4];
        logic [31:0] ra [4];
        logic [31:0] ri [4];
        int          sent, got;
        logic        busy3, accepted;

        vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h1000_0001, 1'b0};
        vecs[2] = '{32'h8000_001C, 32'h1000_0007, 1'b0};
        vecs[3] = '{32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{32'h8000_0002, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0013, 1'b1};
        vecs[6] = '{32'h8000_1000, 32'h0000_0013, 1'b1};

        reset_n = 1'b0; request_i = 1'b0; instAddr_i = 32'd0; flush_i = 1'b0;
        memWe_i = 1'b0; memWAddr_i = 32'd0; memWData_i = 32'd0;
        tick();
        tick();
        @(negedge clk);
        chk("reset dataOk", 32'(dataOk_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset inst", inst_o, 32'd0);
        chk("reset instAddr", instAddr_o, 32'd0);
        tick();
        reset_n = 1'b1;

        bd_write(32'd0, 32'h0010_0093);
        for (int i = 1; i < 8; i++) bd_write(32'(i), 32'h1000_0000 + 32'(i));
        bd_write(32'd1023, 32'hDEAD_BEEF);

        for (int i = 0; i < 7; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inst, vecs[i].err);
        end

        // Back-to-back: request held high across four addresses.
        ba[0] = 32'h8000_0000; ba[1] = 32'h8000_0004; ba[2] = 32'h8000_0008; ba[3] = 32'h8000_000C;
        bi[0] = 32'h0010_0093; bi[1] = 32'h1000_0001; bi[2] = 32'h1000_0002; bi[3] = 32'h1000_0003;
        for (int i = 0; i < 4; i++) begin rt[i] = -1; ra[i] = 32'd0; ri[i] = 32'd0; end
        sent = 0; got = 0; busy3 = 1'b0;
        request_i = 1'b1; instAddr_i = ba[0];
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 3) busy3 = busy_o;
            if (dataOk_o && got < 4) begin
                rt[got] = t; ra[got] = instAddr_o; ri[got] = inst_o; got++;
            end
            accepted = request_i && !busy_o;
            tick();
            if (accepted) begin
                sent++;
                if (sent < 4) instAddr_i = ba[sent];
                else request_i = 1'b0;
            end
        end
        request_i = 1'b0;
        chk("b2b busy_full", 32'(busy3), 32'd1);
        chk("b2b count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b t%0d", i), 32'(rt[i]), 32'(4 + i * (LAT + 1)));
            chk($sformatf("b2b addr%0d", i), ra[i], ba[i]);
            chk($sformatf("b2b inst%0d", i), ri[i], bi[i]);
        end

        // Flush with two requests queued, first one in WAIT.
        request_i = 1'b1; instAddr_i = 32'h8000_0000;
        tick();
        instAddr_i = 32'h8000_0004;
        tick();
        request_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        watch_quiet("flush_wait quiet", 10);
        do_req("post_flush", 32'h8000_0004, 32'h1000_0001, 1'b0);

        // Flush landing exactly on the response cycle.
        request_i = 1'b1; instAddr_i = 32'h8000_0008;
        tick();
        request_i = 1'b0;
        tick();
        tick();
        tick();
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_resp dataOk", 32'(dataOk_o), 32'd0);
        chk("flush_resp err", 32'(err_o), 32'd0);
        tick();
        flush_i = 1'b0;
        watch_quiet("flush_resp quiet", 6);

        // Reset pulse while in WAIT; a backdoor write during reset must be ignored.
        request_i = 1'b1; instAddr_i = 32'h8000_0000;
        tick();
        request_i = 1'b0;
        tick();
        reset_n = 1'b0;
        memWe_i = 1'b1; memWAddr_i = 32'd0; memWData_i = 32'hBAD0_BAD0;
        tick();
        reset_n = 1'b1;
        memWe_i = 1'b0;
        @(negedge clk);
        chk("midreset dataOk", 32'(dataOk_o), 32'd0);
        chk("midreset busy", 32'(busy_o), 32'd0);
        chk("midreset err", 32'(err_o), 32'd0);
        chk("midreset inst", inst_o, 32'd0);
        chk("midreset instAddr", instAddr_o, 32'd0);
        tick();
        watch_quiet("midreset quiet", 8);
        do_req("post_reset mem", 32'h8000_0000, 32'h0010_0093, 1'b0);

        // Backdoor write to index 5 in the same cycle the memory is read.
        request_i = 1'b1; instAddr_i = 32'h8000_0014;
        tick();
        request_i = 1'b0;
        tick();
        tick();
        memWe_i = 1'b1; memWAddr_i = 32'd5; memWData_i = 32'hCAFE_F00D;
        tick();
        memWe_i = 1'b0;
        @(negedge clk);
        chk("rbw dataOk", 32'(dataOk_o), 32'd1);
        chk("rbw old_word", inst_o, 32'h1000_0005);
        tick();
        do_req("rbw new_word", 32'h8000_0014, 32'hCAFE_F00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
